// File: rtl/hc148_irq_ctrl.sv
// 74HC148-style interrupt controller: synchronised edge capture, mask, fixed/rotating priority, req/ack/eoi handshake.
// Optional macro HC148_ROT_PRIO_EN selects rotating priority; the default build uses fixed priority (7 highest).
module hc148_irq_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 0,
  parameter int TMR_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ir_n,
  input  logic       ei_n,
  input  logic       mask_wr,
  input  logic [7:0] mask_in,
  input  logic       ack,
  input  logic       eoi,
  output logic       irq,
  output logic [2:0] vec,
  output logic       busy,
  output logic [7:0] pend,
  output logic       gs_n,
  output logic       eo_n,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);

  state_t                          state, state_d;
  logic [SYNC_STAGES-1:0][7:0]     sync_q;
  logic [7:0]                      ir_s, ir_prev, fall, mask, req, clr;
  logic [TMR_W-1:0]                timer, timer_d;
  logic                            irq_d, busy_d, timeout_d, any, tmo_hit;
  logic [2:0]                      vec_d, win, idx, lo;

  assign ir_s = sync_q[SYNC_STAGES-1];
  assign fall = ir_prev & ~ir_s;
  assign req  = pend & ~mask;
  assign any  = |req;
  assign gs_n = ei_n | ~any;
  assign eo_n = ei_n | any;
  assign tmo_hit = (ACK_TIMEOUT != 0) && (timer == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      ir_prev <= 8'hFF;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], ir_n};
      ir_prev <= ir_s;
    end
  end

`ifdef HC148_ROT_PRIO_EN
  // lo marks the lowest-priority line; lo-1 (with wrap) is the highest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lo <= 3'd0;
    else if (state == SERV && eoi) lo <= vec;
  end
`else
  assign lo = 3'd0;
`endif

  // Scanning from lo upward, the last hit is the highest-priority request.
  always_comb begin
    win = 3'd0;
    idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      idx = lo + 3'(k);
      if (req[idx]) win = idx;
    end
  end

  always_comb begin
    state_d   = state;
    irq_d     = irq;
    vec_d     = vec;
    busy_d    = busy;
    timer_d   = timer;
    timeout_d = 1'b0;
    clr       = 8'h00;
    case (state)
      IDLE: begin
        if (!ei_n && any) begin
          state_d = REQ;
          vec_d   = win;
          irq_d   = 1'b1;
          timer_d = '0;
        end
      end
      REQ: begin
        if (ack) begin
          clr[vec] = 1'b1;
          irq_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = SERV;
        end else if (tmo_hit) begin
          irq_d     = 1'b0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      SERV: begin
        if (eoi) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      irq     <= 1'b0;
      vec     <= 3'd0;
      busy    <= 1'b0;
      timer   <= '0;
      timeout <= 1'b0;
      pend    <= 8'h00;
      mask    <= 8'h00;
    end else begin
      state   <= state_d;
      irq     <= irq_d;
      vec     <= vec_d;
      busy    <= busy_d;
      timer   <= timer_d;
      timeout <= timeout_d;
      // A new edge wins over the clear from an ack on the same line.
      pend    <= (pend & ~clr) | fall;
      if (mask_wr) mask <= mask_in;
    end
  end

endmodule
